// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing the mem write port and rd1 read port between
// the core load/store path (req0) and a host/debug loader (req1).
module mem_arbiter #(
    parameter int n        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic         we0,
    input  logic         we1,
    input  logic [n-1:0] addr0,
    input  logic [n-1:0] addr1,
    input  logic [n-1:0] wdata0,
    input  logic [n-1:0] wdata1,
    output logic         gnt0,
    output logic         gnt1,
    output logic [n-1:0] rdata0,
    output logic [n-1:0] rdata1,
    output logic         rvalid0,
    output logic         rvalid1,
    output logic         wr_en,
    output logic [n-1:0] wr_addr,
    output logic [n-1:0] wr_data,
    output logic [n-1:0] rd_addr,
    input  logic [n-1:0] rd_data
);

    localparam int HW = $clog2(MAX_HOLD) + 1;

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t         r_state, w_next;
    logic           r_ptr;
    logic [HW-1:0]  r_hold, w_hold_next;
    logic [n-1:0]   r_rdata0, r_rdata1;
    logic           r_rvalid0, r_rvalid1;
    logic           w_srv0, w_srv1, w_other_req, w_under;

    assign gnt0    = (r_state == OWN0);
    assign gnt1    = (r_state == OWN1);
    assign w_srv0  = gnt0 & req0;
    assign w_srv1  = gnt1 & req1;
    assign w_under = (int'(r_hold) < MAX_HOLD - 1);

    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;

    always_comb begin
        w_next      = r_state;
        w_other_req = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0 && req1) w_next = r_ptr ? OWN1 : OWN0;
                else if (req0)    w_next = OWN0;
                else if (req1)    w_next = OWN1;
            end
            OWN0: begin
                w_other_req = req1;
                if (req0 && (!req1 || w_under)) w_next = OWN0;
                else if (req1)                  w_next = OWN1;
                else                            w_next = IDLE;
            end
            OWN1: begin
                w_other_req = req0;
                if (req1 && (!req0 || w_under)) w_next = OWN1;
                else if (req0)                  w_next = OWN0;
                else                            w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Hold count only accumulates under contention and saturates at all-ones.
    always_comb begin
        w_hold_next = r_hold;
        if (w_next != r_state || !w_other_req)
            w_hold_next = '0;
        else if ((w_srv0 || w_srv1) && r_hold != {HW{1'b1}})
            w_hold_next = r_hold + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_ptr     <= 1'b0;
            r_hold    <= '0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_hold    <= w_hold_next;
            if (w_srv0)      r_ptr <= 1'b1;
            else if (w_srv1) r_ptr <= 1'b0;
            r_rvalid0 <= w_srv0 & ~we0;
            r_rvalid1 <= w_srv1 & ~we1;
            if (w_srv0 && !we0) r_rdata0 <= rd_data;
            if (w_srv1 && !we1) r_rdata1 <= rd_data;
        end
    end

    // Mem-side mux is decoded from state so reset kills wr_en immediately.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        case (r_state)
            OWN0: begin
                wr_en   = req0 & we0;
                wr_addr = addr0;
                wr_data = wdata0;
                rd_addr = addr0;
            end
            OWN1: begin
                wr_en   = req1 & we1;
                wr_addr = addr1;
                wr_data = wdata1;
                rd_addr = addr1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a MAX_HOLD=4 instance with a memory model
// and a MAX_HOLD=1 instance sharing the same requester stimulus.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;

    logic       gnt0, gnt1, rvalid0, rvalid1, wr_en;
    logic [7:0] rdata0, rdata1, wr_addr, wr_data, rd_addr, rd_data;

    logic       b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_wr_en;
    logic [7:0] b_rdata0, b_rdata1, b_wr_addr, b_wr_data, b_rd_addr;
    logic [7:0] b_rd_data = '0;

    logic [7:0] mem [256];
    logic [7:0] exp_mem [256];

    logic [15:0] wq [$];
    logic [7:0]  rdq0 [$];
    logic [7:0]  rdq1 [$];

    int   n_cmp = 0, n_err = 0;
    bit   sb_en = 1'b1;
    logic [1:0]  g_seen, bg_seen, rv_seen;
    logic        wr_seen;
    logic [24:0] sa_seen, sb_seen;
    int   waits;

    always #5 clk = ~clk;

    always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;
    assign rd_data = mem[rd_addr];

    mem_arbiter #(.n(8), .MAX_HOLD(4)) u_a (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data));

    mem_arbiter #(.n(8), .MAX_HOLD(1)) u_b (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .rdata0(b_rdata0), .rdata1(b_rdata1),
        .rvalid0(b_rvalid0), .rvalid1(b_rvalid1), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .rd_addr(b_rd_addr), .rd_data(b_rd_data));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic unexpected(input string tag, input logic [15:0] obs);
        n_cmp++;
        n_err++;
        $error("FAIL %s: observed %0h expected no event", tag, obs);
    endtask

    // One clock cycle: sample mid-cycle, pop the scoreboard, return just after the edge.
    task automatic cyc();
        logic [15:0] w;
        logic [7:0]  r;
        @(negedge clk);
        g_seen  = {gnt1, gnt0};
        bg_seen = {b_gnt1, b_gnt0};
        rv_seen = {rvalid1, rvalid0};
        wr_seen = wr_en;
        sa_seen = {wr_en, wr_addr, wr_data, rd_addr};
        sb_seen = {b_wr_en, b_wr_addr, b_wr_data, b_rd_addr};
        chk("gnt_excl", {62'd0, gnt0 & gnt1}, 64'd0);
        chk("b_gnt_excl", {62'd0, b_gnt0 & b_gnt1}, 64'd0);
        if (sb_en) begin
            if (wr_en) begin
                if (wq.size() == 0) unexpected("wr_spurious", {wr_addr, wr_data});
                else begin w = wq.pop_front(); chk("wr_bus", {wr_addr, wr_data}, w); end
            end
            if (rvalid0) begin
                if (rdq0.size() == 0) unexpected("rvalid0_spurious", {8'd0, rdata0});
                else begin r = rdq0.pop_front(); chk("rdata0", rdata0, r); end
            end
            if (rvalid1) begin
                if (rdq1.size() == 0) unexpected("rvalid1_spurious", {8'd0, rdata1});
                else begin r = rdq1.pop_front(); chk("rdata1", rdata1, r); end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input bit id, input bit we, input logic [7:0] a,
                        input logic [7:0] d, output int lat);
        lat = -1;
        if (we) begin wq.push_back({a, d}); exp_mem[a] = d; end
        else if (id) rdq1.push_back(exp_mem[a]);
        else rdq0.push_back(exp_mem[a]);
        if (id) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        else begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (g_seen[id]) begin lat = i; break; end
        end
        if (id) req1 = 1'b0; else req0 = 1'b0;
        if (lat < 0) unexpected("xact_timeout", {a, d});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ctl"}, {gnt0, gnt1, rvalid0, rvalid1, wr_en}, 64'd0);
        chk({tag, "_rdata"}, {rdata0, rdata1}, 64'd0);
        chk({tag, "_bus"}, {wr_addr, wr_data, rd_addr}, 64'd0);
        chk({tag, "_b"}, {b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_wr_en,
                          b_rdata0, b_rdata1}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ea, eb;
        logic [24:0] ba, bb;
        // Reset low for 10 ns
        #2;
        chk_reset_vals("reset");
        #8 reset = 1'b1;
        @(posedge clk); #1;

        // Single write from requester 0
        xact(1'b0, 1'b1, 8'h80, 8'hAA, waits);
        chk("wr0_latency", waits, 64'd1);
        chk("mem128_aa", mem[8'h80], 64'd170);
        cyc();
        chk("wr0_one_cycle", {63'd0, wr_seen}, 64'd0);

        // Preload 13, then read it back through requester 1 (handover from OWN0)
        xact(1'b0, 1'b1, 8'h80, 8'd13, waits);
        chk("mem128_13", mem[8'h80], 64'd13);
        xact(1'b1, 1'b0, 8'h80, 8'h00, waits);
        chk("rd1_latency", waits, 64'd1);
        cyc();
        chk("rvalid1_pulse", {62'd0, rv_seen}, 64'd2);
        chk("rdq1_drained", rdq1.size(), 64'd0);
        cyc();
        chk("rvalid1_gone", {62'd0, rv_seen}, 64'd0);

        // Uncontended hold: no limit applies
        sb_en = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h30; wdata0 = 8'h01;
        cyc();
        chk("unc_latency", {62'd0, g_seen}, 64'd0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("unc_hold_gnt0", {62'd0, g_seen}, 64'd1);
        end
        req0 = 1'b0;
        cyc();
        chk("unc_drop_gnt", {62'd0, g_seen}, 64'd1);
        chk("unc_drop_no_wr", {63'd0, wr_seen}, 64'd0);
        cyc();
        chk("unc_drop_idle", {62'd0, g_seen}, 64'd0);
        sb_en = 1'b1;

        // Reset during a granted write from requester 1
        xact(1'b0, 1'b1, 8'hFF, 8'h11, waits);
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'hFF; wdata1 = 8'h55;
        cyc();
        @(negedge clk);
        chk("mid_gnt1", {gnt1, wr_en, wr_addr, wr_data}, {2'b11, 8'hFF, 8'h55});
        #1 reset = 1'b0;
        #1;
        chk("mid_wr_en_drop", {gnt1, wr_en}, 64'd0);
        @(posedge clk); #1;
        req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
        @(negedge clk);
        chk("mem255_kept", mem[8'hFF], 64'h11);
        reset = 1'b1;
        #1;
        chk_reset_vals("post_reset");
        @(posedge clk); #1;

        // Tie after reset, continuous contention (MAX_HOLD 4 and 1)
        sb_en = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'hA0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 8'hB1;
        cyc();
        chk("tie_latency", {g_seen, bg_seen}, 64'd0);
        for (int i = 0; i < 16; i++) begin
            cyc();
            ea = ((i / 4) % 2 == 1) ? 2'b10 : 2'b01;
            eb = (i % 2 == 1) ? 2'b10 : 2'b01;
            ba = ea[1] ? {1'b1, 8'h20, 8'hB1, 8'h20} : {1'b1, 8'h10, 8'hA0, 8'h10};
            bb = eb[1] ? {1'b1, 8'h20, 8'hB1, 8'h20} : {1'b1, 8'h10, 8'hA0, 8'h10};
            chk("cont_gnt_h4", {62'd0, g_seen}, {62'd0, ea});
            chk("cont_gnt_h1", {62'd0, bg_seen}, {62'd0, eb});
            chk("cont_bus_h4", {39'd0, sa_seen}, {39'd0, ba});
            chk("cont_bus_h1", {39'd0, sb_seen}, {39'd0, bb});
        end
        req0 = 1'b0; req1 = 1'b0;
        cyc();
        chk("cont_drop_no_wr", {63'd0, wr_seen}, 64'd0);
        cyc();
        chk("cont_idle", {g_seen, bg_seen}, 64'd0);
        sb_en = 1'b1;

        chk("wq_empty", wq.size(), 64'd0);
        chk("rdq0_empty", rdq0.size(), 64'd0);
        chk("rdq1_empty", rdq1.size(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single write port and the load read port (rd1) of `mem` between the `w450` core's load/store path (requester 0) and a host/debug loader (requester 1). Only one requester drives the memory address and data in any cycle. Grants are registered, use round-robin tie-breaking, and are bounded by a hold limit so neither side starves. It sits between `w450` (`ld_*`/`st_*`) and `mem` (`rd1_*`, `wr_*`); the instruction fetch port (rd0) bypasses it.

## Interface
- `n`, 8, data and address width.
- `MAX_HOLD`, 4, maximum consecutive granted cycles to one requester while the other is requesting (≥1).

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req0` / `req1`  in  1  transaction request; held until granted.
- `we0` / `we1`  in  1  1 = write, 0 = read; stable while `req` is high.
- `addr0` / `addr1`  in  n  transaction address.
- `wdata0` / `wdata1`  in  n  write data.
- `gnt0` / `gnt1`  out  1  requester owns the memory port this cycle.
- `rdata0` / `rdata1`  out  n  registered read data.
- `rvalid0` / `rvalid1`  out  1  one-cycle pulse: `rdata` is valid.
- `wr_en`  out  1  to `mem.wr_en`.
- `wr_addr`  out  n  to `mem.wr_addr`.
- `wr_data`  out  n  to `mem.wr_data`.
- `rd_addr`  out  n  to `mem.rd1_addr`.
- `rd_data`  in  n  from `mem.rd1_data`; combinational read.

## Operation
- **States:** IDLE, OWN0, OWN1.
- **Grant decode:** `gnt0` = (state==OWN0) and `gnt1` = (state==OWN1). Each is decoded from state only, never from `req`.
- **Transaction completion:** a transaction completes in a cycle where `gntX && reqX`.
  - Write: `wr_en`=1, `wr_addr`=`addrX`, `wr_data`=`wdataX`. `mem` commits the write at that cycle's edge.
  - Read: `rd_addr`=`addrX`. `rd_data` is captured into `rdataX` at the edge, and `rvalidX`=1 for the next cycle.
- **Mem-side defaults:** when no transaction completes, `wr_en`=0. `wr_addr`, `wr_data` and `rd_addr` are 0 in IDLE and follow the owner's inputs in OWNx (`wr_en` stays 0).
- **Priority pointer `ptr`:** points at the requester that wins the next tie. After any cycle served to X, `ptr` is set to the other requester.
- **Hold counter `hold_cnt`:** counts consecutive served cycles to the owner while the other requester is asserting `req`. It clears on a state change, and whenever the other requester is idle.
- **Next state from IDLE:**
  - Only `req0` high: OWN0. Only `req1` high: OWN1.
  - Both high: OWN[`ptr`].
  - Neither: IDLE.
- **Next state from OWNx:**
  - `reqX` high and (`reqY` low or `hold_cnt` < `MAX_HOLD`−1): stay in OWNx.
  - Otherwise, `reqY` high: OWNy.
  - Otherwise: IDLE.
- **Owner drops `req`:** no transaction occurs that cycle, and the next state follows the rules above.
- **`MAX_HOLD`=1:** under continuous contention, grants strictly alternate every cycle.
- **Width:** `hold_cnt` is sized to $clog2(`MAX_HOLD`)+1 bits and saturates; it never wraps.

## Timing
- **Reset values:** state=IDLE, `ptr`=0, `hold_cnt`=0, `gnt0`=`gnt1`=0, `rvalid0`=`rvalid1`=0, `rdata0`=`rdata1`=0, `wr_en`=0, `wr_addr`=`wr_data`=`rd_addr`=0.
- **Reset assertion:** takes effect immediately. `wr_en` falls asynchronously, so a write in progress when reset falls is not committed, and a pending `rvalid` is dropped.
- **First release after reset:** `req` sampled at edge k gives `gnt` during cycle k+1. That is 1 cycle of latency from IDLE. Serviced reads give `rvalid` in cycle k+2.
- **Back-to-back service:** while OWNx persists, one transaction completes per cycle. `rvalidX` is a one-cycle delayed copy of (`gntX && reqX && !weX`).
- **Handover:** changing owner OWN0→OWN1 costs no idle cycle. The new owner's first transaction completes in the first cycle it is granted.
- **Requester obligation:** `req`, `we`, `addr` and `wdata` stay stable from `req` rising until the edge that completes the transaction.
- **Output glitches:** outputs never glitch mid-cycle from `req` changes, except the mem-side mux, which follows the owner's inputs combinationally.

## Test plan
- **Reset, then single requester:** reset low for 10 ns, then `req0`=1, `we0`=1, `addr0`=8'h80, `wdata0`=8'hAA.
  - Required: `gnt0` the cycle after `req0` is sampled; `wr_en`=1 with `wr_addr`=8'h80, `wr_data`=8'hAA for exactly one cycle; `mem.data[128]`=170.
- **Read path:** `mem.data[128]`=13 preloaded; `req1` read at 8'h80.
  - Required: `gnt1` one cycle after `req1` is sampled; `rvalid1` pulses one cycle after the grant cycle with `rdata1`=13; `rvalid0` stays 0.
- **Tie after reset:** `req0` and `req1` rise on the same edge.
  - Required: OWN0 first (`ptr`=0), then OWN1 after the hold limit, then OWN0 again.
- **Contention with `MAX_HOLD`=4, both continuously requesting:**
  - Required: the grant pattern is 4×`gnt0`, 4×`gnt1`, repeating; with `MAX_HOLD`=1, `gnt` alternates every cycle; no cycle has both `gnt` high.
- **Uncontended hold:** `req0` high for 10 cycles with `req1` low.
  - Required: `gnt0` held all 10 cycles (no hold limit applies); on `req0` low, state goes to IDLE the next cycle.
- **Reset mid-operation:** assert reset during a cycle with `gnt1`, `req1` and write data 8'h55 at 8'hFF.
  - Required: `wr_en` drops immediately; mem[255] is unchanged; after release, all outputs are at their reset values and `ptr`=0.
